// File: rtl/cmd_dispatcher.sv
// Command dispatcher: checks a channel's status flags, then holds a one-hot command drive for HOLD_CYCLES.
// Optional macro CMD_DISPATCH_ABORT_EN cuts the drive short when the active channel's flags rise.
module cmd_dispatcher #(
    parameter int CHANNELS    = 4,
    parameter int SEL_W       = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SEL_W-1:0]    sel,
    input  logic                comando,
    input  logic [CHANNELS-1:0] fa,
    input  logic [CHANNELS-1:0] fb,
    output logic [CHANNELS-1:0] s0_out,
    output logic [CHANNELS-1:0] s1_out,
    output logic                busy,
    output logic                done,
    output logic                rejected,
    output logic                aborted,
    output logic [1:0]          state_dbg
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t              state;
    logic [SEL_W-1:0]    sel_q;
    logic                cmd_q;
    logic [CNT_W-1:0]    cnt;

    logic                sel_ok;
    logic                flag_hit;
    logic [CHANNELS-1:0] sel_onehot;

    // Decode the latched select by loop so a non-power-of-two channel count
    // never indexes past the flag vectors.
    always_comb begin
        sel_ok     = 1'b0;
        flag_hit   = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ok        = 1'b1;
                flag_hit      = fa[i] | fb[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign state_dbg = state;

`ifdef CMD_DISPATCH_ABORT_EN
    logic abort_q;
    assign aborted = abort_q;
`else
    assign aborted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            cmd_q    <= 1'b0;
            cnt      <= '0;
            s0_out   <= '0;
            s1_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rejected <= 1'b0;
`ifdef CMD_DISPATCH_ABORT_EN
            abort_q  <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            rejected <= 1'b0;
`ifdef CMD_DISPATCH_ABORT_EN
            abort_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q <= sel;
                        cmd_q <= comando;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (!sel_ok || flag_hit) begin
                        busy     <= 1'b0;
                        rejected <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt    <= CNT_W'(HOLD_CYCLES - 1);
                        s0_out <= cmd_q ? '0 : sel_onehot;
                        s1_out <= cmd_q ? sel_onehot : '0;
                        state  <= DRIVE;
                    end
                end

                DRIVE: begin
`ifdef CMD_DISPATCH_ABORT_EN
                    // A flag on the active channel wins over a coincident final count.
                    if (flag_hit) begin
                        s0_out  <= '0;
                        s1_out  <= '0;
                        busy    <= 1'b0;
                        abort_q <= 1'b1;
                        state   <= IDLE;
                    end else
`endif
                    if (cnt == '0) begin
                        s0_out <= '0;
                        s1_out <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    s0_out <= '0;
                    s1_out <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Parametrised, clocked command dispatcher for CHANNELS actuator channels. It accepts a start request with a channel select and a command bit, and checks that channel's two status flags are clear. It then drives a one-cycle-registered, one-hot command output to that channel for HOLD_CYCLES cycles, keeping busy high throughout. It supersedes the combinational mux → AND → demux → busy chain in the actuator-control datapath.

## Interface
- CHANNELS, default 4: number of channels; must be ≥ 2.
- SEL_W, default 2: select width; must satisfy 2^SEL_W ≥ CHANNELS.
- HOLD_CYCLES, default 8: cycles the command output is held; must be ≥ 1. Counter width is derived as $clog2(HOLD_CYCLES+1).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- sel  in  SEL_W  channel select; latched with start.
- comando  in  1  command polarity; latched with start; 0 selects s0_out, 1 selects s1_out.
- fa  in  CHANNELS  status flag A per channel; active high = channel not ready.
- fb  in  CHANNELS  status flag B per channel; active high = channel not ready.
- s0_out  out  CHANNELS  one-hot command-0 drive.
- s1_out  out  CHANNELS  one-hot command-1 drive.
- busy  out  1  high in CHECK and DRIVE.
- done  out  1  one-cycle pulse on successful completion.
- rejected  out  1  one-cycle pulse when a request is refused in CHECK.
- aborted  out  1  one-cycle pulse when DRIVE is cut short (see Configuration).

## Operation
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE and the counter to 0.
- FSM states: IDLE, CHECK, DRIVE.
- IDLE
  - start=1 latches sel into sel_q and comando into cmd_q, then goes to CHECK.
  - start=0 stays in IDLE.
- CHECK, one cycle:
  - If sel_q ≥ CHANNELS, or fa[sel_q]=1, or fb[sel_q]=1: go to IDLE and pulse rejected.
  - Otherwise: go to DRIVE, load counter with HOLD_CYCLES-1, and assert bit sel_q of s0_out (cmd_q=0) or of s1_out (cmd_q=1).
- DRIVE
  - Exactly one bit across s0_out and s1_out is high.
  - When counter=0: drop the drive, go to IDLE, pulse done.
  - Otherwise: decrement the counter.
- Inputs sel, comando and start are ignored outside IDLE. The latched values govern the whole transaction.
- Outside DRIVE, s0_out and s1_out are all zero.
- done, rejected and aborted are mutually exclusive and never coincide with busy=1.
- Reset asserted mid-transaction immediately (asynchronously) clears all outputs, including drive bits, and returns to IDLE. No done or aborted pulse follows.

## Timing
- start sampled at edge E0 → busy=1 after E0.
- Drive bit asserted after E1 and held for exactly HOLD_CYCLES cycles (edges E1 through E_HOLD_CYCLES).
- After E(HOLD_CYCLES+1): drive low, busy=0, done=1 for one cycle. Start-to-done latency is HOLD_CYCLES+2 edges.
- Rejection: rejected=1 and busy=0 after E1. No drive bit ever rises.
- Back-to-back: start=1 in the cycle done (or rejected) is high is accepted, because the FSM is already in IDLE. The next busy rises after that edge with no idle gap.
- fa and fb are treated as synchronous to clk; no synchroniser is included.

## Configuration
- CMD_DISPATCH_ABORT_EN defined:
  - In DRIVE, fa[sel_q]|fb[sel_q] is sampled every edge.
  - If it is high at an edge, the drive drops after that edge, the FSM goes to IDLE, aborted=1 for one cycle, busy=0, and done is suppressed.
- CMD_DISPATCH_ABORT_EN undefined:
  - Flags are checked only in CHECK; DRIVE always runs the full HOLD_CYCLES.
  - aborted is tied to 0.

## Test plan
- Defaults, fa=fb=0, sel=2, comando=1, start pulse at E0 → s1_out=4'b0100 for exactly 8 cycles starting after E1; done pulse after E9; busy high after E0 through E8; s0_out stays 0.
- fb=4'b0010, sel=1, comando=0, start → rejected=1 after E1; s0_out and s1_out stay 0; busy high for one cycle only.
- CHANNELS=3, sel=3 → rejected=1 after E1, no drive.
- start held high continuously, sel=0, comando=0 → repeated transactions every HOLD_CYCLES+2 cycles with no idle gap; sel changes mid-DRIVE do not move the active bit.
- rst_n low during the 4th DRIVE cycle → all outputs 0 immediately; state IDLE; no done after reset release.
- With CMD_DISPATCH_ABORT_EN: fa[sel_q] rises in the 3rd DRIVE cycle → drive low on the next edge, aborted=1 for one cycle, no done. Without the macro: same stimulus gives the full 8-cycle drive and done.
